pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised successor to the 2-bit ripple adder: a WIDTH-bit adder/subtractor split into STAGES registered carry-chunks.
- Valid/ready handshake on input and output, carry-out and signed-overflow flags.
- Sits wherever a wide add is needed at full clock rate: one result per cycle, fixed latency, stalls under downstream backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 1.
- STAGES, 4, pipeline stages; WIDTH % STAGES == 0 required, else elaboration error; CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- lhs  input  WIDTH  left operand.
- rhs  input  WIDTH  right operand.
- cin  input  1  carry-in.
- sub  input  1  1 = subtract mode (rhs inverted).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  sum/difference.
- cout  output  1  carry-out of MSB (not a borrow).
- ovf  output  1  signed overflow.

Behaviour:
- Reset (reset=0, async): all stage valid bits, data, carries and outputs cleared; out_valid=0, out=0, cout=0, ovf=0; in_ready=1 once reset deasserts.
- Operation: effective B = sub ? ~rhs : rhs; result = lhs + B + cin, computed mod 2^WIDTH. Subtract callers drive cin=1 for lhs−rhs.
- Stage k (0..STAGES−1) adds chunk k of lhs and B plus the carry registered by stage k−1 (cin for k=0). It registers CHUNK sum bits and the chunk carry.
- Upper operand chunks and completed lower sum chunks are skewed through delay registers so every chunk of a transaction exits together.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Latency: a transfer accepted at edge N (in_valid & in_ready) has out_valid=1 after edge N+STAGES−1, with out/cout/ovf valid. STAGES=1 gives a registered adder with 1-cycle latency.
- Throughput: one transaction per cycle when out_ready=1.
- Stall: global enable en = ~out_valid | out_ready; in_ready = en. When en=0 every pipeline register holds, so out/cout/ovf stay stable while out_valid=1 and out_ready=0.
- Bubbles (in_valid=0 while en=1) propagate as valid=0 stages. Bubbles are not collapsed during stall.
- Simultaneous accept and emit in the same cycle is legal and lossless.
- in_valid is ignored when in_ready=0; upstream must hold operands.
- Outputs stay in order; no reordering and no drops.
- Reset mid-operation flushes all in-flight transactions; nothing is emitted afterwards.
- Carry across a chunk boundary (e.g. 0x0F+0x01 at CHUNK=4) must propagate correctly through the stage register.

Decomposition:
- Package pipelined_adder_pkg holds CHUNK derivation and the WIDTH/STAGES legality check function.
- Sub-module adder_stage: one CHUNK-bit registered slice with enable (inputs a, b, carry_in, valid_in; registered sum, carry_out, valid_out).
- Skew/deskew delay lines are generate loops in the top level.

Test Plan (WIDTH=8, STAGES=4 unless stated):
- Reset: hold reset=0 for 3 cycles, in_valid=1 → out_valid=0, out=0x00, cout=0, ovf=0, no output after release until a new accept.
- Carry ripple: lhs=0xFF, rhs=0x01, cin=0, sub=0 → 4 cycles later out=0x00, cout=1, ovf=0; lhs=0x7F, rhs=0x01 → out=0x80, cout=0, ovf=1.
- Streaming: 0x01+0x01, 0x10+0x10, 0x0F+0x01, 0xF0+0x20 on consecutive cycles, out_ready=1 → 0x02, 0x20, 0x10, 0x10(cout=1) on 4 consecutive cycles starting at latency 4.
- Backpressure: stream 6 transactions, drop out_ready for 5 cycles mid-stream → in_ready=0 during stall, out stable, all 6 results emitted in order, none duplicated.
- Subtract: lhs=0x05, rhs=0x07, sub=1, cin=1 → out=0xFE, cout=0, ovf=0; lhs=0x80, rhs=0x01, sub=1, cin=1 → out=0x7F, cout=1, ovf=1.
- Reset mid-flight / param sweep: accept 3 ops, assert reset for 1 cycle → no outputs follow; repeat the carry-ripple scenario with STAGES=1, 2, 8 and WIDTH=16, STAGES=4, checking latency = STAGES.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared configuration helpers for the pipelined adder/subtractor.
package pipelined_adder_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STAGES = 4;

  // True when the operand width splits evenly into non-empty stage chunks.
  function automatic bit cfg_legal(input int unsigned width, input int unsigned stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Bits handled per stage; clamped to 1 so an illegal config still elaborates to its error.
  function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
    if ((stages == 0) || (width < stages)) return 1;
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One registered CHUNK-bit slice of the carry chain, held when en is low.
module adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carry_in,
  input  logic             valid_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out,
  output logic             ovf,
  output logic             valid_out
);

  localparam int unsigned SW = CHUNK + 1;

  logic [SW-1:0]    total;
  logic             msb_cin;
  logic [CHUNK-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
  logic             valid_d, valid_q;

  // Chunk add; ovf is only meaningful for the slice holding the operand MSB.
  always_comb begin
    total   = SW'(a) + SW'(b) + SW'(carry_in);
    msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ total[CHUNK-1];
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    if (en) begin
      sum_d   = total[CHUNK-1:0];
      carry_d = total[CHUNK];
      ovf_d   = msb_cin ^ total[CHUNK];
      valid_d = valid_in;
    end
  end

  // Slice registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign ovf       = ovf_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder/subtractor pipelined as STAGES carry-chunks with valid/ready flow control.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
  localparam int unsigned LAST  = STAGES - 1;

  if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be >= 1 and an exact multiple of STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic [CHUNK-1:0] stg_a   [STAGES];
  logic [CHUNK-1:0] stg_b   [STAGES];
  logic [CHUNK-1:0] stg_sum [STAGES];
  logic [STAGES-1:0] stg_cin, stg_vin, stg_cout, stg_vout, stg_ovf;

  // Whole pipeline advances together unless a held result is blocked downstream.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign b_eff    = sub ? ~rhs : rhs;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned DEPTH = LAST - k;

    if (k == 0) begin : g_head
      assign stg_a[k]   = lhs[CHUNK-1:0];
      assign stg_b[k]   = b_eff[CHUNK-1:0];
      assign stg_cin[k] = cin;
      assign stg_vin[k] = in_valid;
    end else begin : g_skew
      logic [2*CHUNK-1:0] ab_d [k];
      logic [2*CHUNK-1:0] ab_q [k];

      // Delay upper operand chunks so they meet the carry from the stage below.
      always_comb begin
        ab_d = ab_q;
        if (en) begin
          ab_d[0] = {lhs[k*CHUNK +: CHUNK], b_eff[k*CHUNK +: CHUNK]};
          for (int j = 1; j < k; j++) ab_d[j] = ab_q[j-1];
        end
      end

      // Operand skew registers.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) ab_q <= '{default: '0};
        else        ab_q <= ab_d;
      end

      assign {stg_a[k], stg_b[k]} = ab_q[k-1];
      assign stg_cin[k] = stg_cout[k-1];
      assign stg_vin[k] = stg_vout[k-1];
    end

    adder_stage #(.CHUNK(CHUNK)) u_stage (
      .clk       (clk),
      .rst_n     (reset),
      .en        (en),
      .a         (stg_a[k]),
      .b         (stg_b[k]),
      .carry_in  (stg_cin[k]),
      .valid_in  (stg_vin[k]),
      .sum       (stg_sum[k]),
      .carry_out (stg_cout[k]),
      .ovf       (stg_ovf[k]),
      .valid_out (stg_vout[k])
    );

    if (DEPTH == 0) begin : g_tail
      assign out[k*CHUNK +: CHUNK] = stg_sum[k];
    end else begin : g_deskew
      logic [CHUNK-1:0] sum_d [DEPTH];
      logic [CHUNK-1:0] sum_q [DEPTH];

      // Hold finished low chunks until the top chunk of the same transaction completes.
      always_comb begin
        sum_d = sum_q;
        if (en) begin
          sum_d[0] = stg_sum[k];
          for (int j = 1; j < int'(DEPTH); j++) sum_d[j] = sum_q[j-1];
        end
      end

      // Result deskew registers.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) sum_q <= '{default: '0};
        else        sum_q <= sum_d;
      end

      assign out[k*CHUNK +: CHUNK] = sum_q[DEPTH-1];
    end
  end

  assign out_valid = stg_vout[LAST];
  assign cout      = stg_cout[LAST];
  assign ovf       = stg_ovf[LAST];

  // Lower slices also compute a chunk-local overflow that has no consumer.
  logic unused_ovf;
  assign unused_ovf = &{1'b0, stg_ovf};

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed-vector bench for pipelined_adder plus a latency sweep over several configurations.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [7:0] lhs, rhs, out;

  pipelined_adder #(.WIDTH(8), .STAGES(4)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .lhs(lhs), .rhs(rhs), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .cout(cout), .ovf(ovf)
  );

  // Sweep instances: [0]=8x1, [1]=8x2, [2]=8x8, [3]=16x4, all fed an all-ones + 1 add.
  logic        sw_valid, sw_ready;
  logic [3:0]  sw_in_ready, sw_out_valid, sw_cout, sw_ovf;
  logic [7:0]  s_out [3];
  logic [15:0] w_out;

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .reset(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[0]),
    .lhs(8'hFF), .rhs(8'h01), .cin(1'b0), .sub(1'b0),
    .out_valid(sw_out_valid[0]), .out_ready(sw_ready), .out(s_out[0]), .cout(sw_cout[0]), .ovf(sw_ovf[0])
  );
  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_s2 (
    .clk(clk), .reset(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[1]),
    .lhs(8'hFF), .rhs(8'h01), .cin(1'b0), .sub(1'b0),
    .out_valid(sw_out_valid[1]), .out_ready(sw_ready), .out(s_out[1]), .cout(sw_cout[1]), .ovf(sw_ovf[1])
  );
  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .reset(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[2]),
    .lhs(8'hFF), .rhs(8'h01), .cin(1'b0), .sub(1'b0),
    .out_valid(sw_out_valid[2]), .out_ready(sw_ready), .out(s_out[2]), .cout(sw_cout[2]), .ovf(sw_ovf[2])
  );
  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_w16 (
    .clk(clk), .reset(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[3]),
    .lhs(16'hFFFF), .rhs(16'h0001), .cin(1'b0), .sub(1'b0),
    .out_valid(sw_out_valid[3]), .out_ready(sw_ready), .out(w_out), .cout(sw_cout[3]), .ovf(sw_ovf[3])
  );

  typedef struct {
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic       cin;
    logic       sub;
    logic [7:0] e_out;
    logic       e_cout;
    logic       e_ovf;
    logic       lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   idx;
    int   acc_cyc;
  } exp_t;

  vec_t tbl [14];
  exp_t q [$];
  vec_t cur;
  int   cur_idx;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   sw_lat [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Score the transfers that happen at the coming edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check($sformatf("out[%0d]", e.idx),  32'(out),  32'(e.v.e_out));
        check($sformatf("cout[%0d]", e.idx), 32'(cout), 32'(e.v.e_cout));
        check($sformatf("ovf[%0d]", e.idx),  32'(ovf),  32'(e.v.e_ovf));
        if (e.v.lat) check($sformatf("latency[%0d]", e.idx), 32'(cyc - e.acc_cyc), 32'd4);
      end
    end
    if (in_valid && in_ready) begin
      e.v       = cur;
      e.idx     = cur_idx;
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Stream tbl[first..last]; out_ready drops for stall_len cycles from stall_at.
  task automatic run(input int first, input int last, input int stall_at, input int stall_len);
    int  idx;
    int  t;
    logic acc;
    idx = first;
    t   = 0;
    while ((idx <= last || q.size() != 0) && t < 100) begin
      if (idx <= last) begin
        cur      = tbl[idx];
        cur_idx  = idx;
        in_valid = 1'b1;
        lhs      = cur.lhs;
        rhs      = cur.rhs;
        cin      = cur.cin;
        sub      = cur.sub;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(t >= stall_at && t < stall_at + stall_len);
      #0;
      if (!out_ready && out_valid) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        if (q.size() > 0) check("stall_out", 32'(out), 32'(q[0].v.e_out));
        else              check("stall_empty_q", 32'(q.size()), 32'd1);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      t++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check($sformatf("run_done[%0d..%0d]", first, last), 32'((idx > last) && (q.size() == 0)), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               lhs     rhs    cin   sub   out    cout  ovf   lat
    tbl[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{8'h10, 8'h10, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{8'hC0, 8'hC0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    lhs       = 8'h12;
    rhs       = 8'h34;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    sw_valid  = 1'b0;
    sw_ready  = 1'b1;
    cur       = tbl[0];
    cur_idx   = 0;

    // Reset held with operands offered: nothing may appear.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out",       32'(out),       32'd0);
      check("rst_cout",      32'(cout),      32'd0);
      check("rst_ovf",       32'(ovf),       32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #0;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (6) begin
      check("post_rst_idle", 32'(out_valid), 32'd0);
      tick();
    end

    run(0, 1, -1, 0);   // carry ripple and signed overflow
    run(2, 5, -1, 0);   // back-to-back stream
    run(6, 7, -1, 0);   // subtract
    run(8, 13, 5, 5);   // backpressure mid-stream
    repeat (3) tick();  // no duplicates after drain

    // Accept three operations, then reset: all must be lost.
    cur      = tbl[2];
    cur_idx  = 2;
    lhs      = cur.lhs;
    rhs      = cur.rhs;
    cin      = cur.cin;
    sub      = cur.sub;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    repeat (8) begin
      check("post_flush_idle", 32'(out_valid), 32'd0);
      tick();
    end

    // Latency sweep over other configurations.
    sw_lat = '{-1, -1, -1, -1};
    check("sw_in_ready", 32'(sw_in_ready), 32'hF);
    sw_valid = 1'b1;
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (sw_out_valid[i] && sw_lat[i] < 0) begin
          sw_lat[i] = t;
          if (i < 3) check($sformatf("sw_out[%0d]", i), 32'(s_out[i]), 32'd0);
          else       check("sw_out[3]", 32'(w_out), 32'd0);
          check($sformatf("sw_cout[%0d]", i), 32'(sw_cout[i]), 32'd1);
          check($sformatf("sw_ovf[%0d]", i),  32'(sw_ovf[i]),  32'd0);
        end
      end
      @(posedge clk);
      #1;
    end
    check("sw_lat_s1",  32'(sw_lat[0]), 32'd1);
    check("sw_lat_s2",  32'(sw_lat[1]), 32'd2);
    check("sw_lat_s8",  32'(sw_lat[2]), 32'd8);
    check("sw_lat_w16", 32'(sw_lat[3]), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
